// File: rtl/bootloader_pkg.sv
// Shared types and constants for the boot sequencer.
package bootloader_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam int unsigned BOOT_DEFAULT_WORDS = 'h120;
   localparam int unsigned RD_LATENCY_MIN     = 1;
   localparam int unsigned RD_LATENCY_MAX     = 4;

   // The wait counter is sized for at most four cycles of boot-memory latency.
   function automatic bit rd_latency_ok(input int unsigned lat);
      return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/boot_chksum.sv
// Additive checksum accumulator, wraps modulo 2^DATA_WIDTH.
module boot_chksum #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  add_en_i,
   input  logic [DATA_WIDTH-1:0] add_data_i,
   output logic [DATA_WIDTH-1:0] sum_o
);

   logic [DATA_WIDTH-1:0] sum_q;
   logic [DATA_WIDTH-1:0] sum_d;

   // Clear has priority so a fresh boot always starts from zero.
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (add_en_i) begin
         sum_d = sum_q + add_data_i;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/bootloader_ctrl.sv
// Boot sequencer: copies an image from boot ROM into instruction SRAM and
// holds the core in boot mode until the copy is complete and verified.
//
// state | meaning
// INIT  | latch configuration, clear index and checksum
// READ  | strobe boot-memory read of src_base + idx
// WAIT  | wait RD_LATENCY cycles, capture data on the last one
// WRITE | request instruction-memory write, hold until ready
// CHECK | compare running sum against expected value
// DONE  | image loaded, core released
// ERROR | checksum mismatch, core stays in boot
module bootloader_ctrl
   import bootloader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 20,
   parameter int unsigned RD_LATENCY    = 1,
   parameter int unsigned ADDR_SHIFT    = 2,
   parameter int unsigned DEFAULT_WORDS = BOOT_DEFAULT_WORDS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_words,
   input  logic [ADDR_WIDTH-1:0] cfg_src_base,
   input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
   input  logic                  cfg_chk_en,
   input  logic [DATA_WIDTH-1:0] cfg_checksum,
   output logic                  boot_mem_rd_en,
   output logic [ADDR_WIDTH-1:0] boot_mem_addr,
   input  logic [DATA_WIDTH-1:0] boot_mem_rd_data,
   output logic                  inst_mem_wr_en,
   input  logic                  inst_mem_ready,
   output logic [ADDR_WIDTH-1:0] inst_mem_addr,
   output logic [DATA_WIDTH-1:0] inst_mem_wr_data,
   output logic                  boot_mode,
   output logic                  boot_done,
   output logic                  boot_err,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam int unsigned LAT_W = 2;

   if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
      $error("bootloader_ctrl: RD_LATENCY must lie in 1..4");
   end

   state_t                state_q,   state_d;
   logic [ADDR_WIDTH-1:0] idx_q,     idx_d;
   logic [ADDR_WIDTH-1:0] words_q,   words_d;
   logic [ADDR_WIDTH-1:0] src_q,     src_d;
   logic [ADDR_WIDTH-1:0] dst_q,     dst_d;
   logic                  chk_en_q,  chk_en_d;
   logic [DATA_WIDTH-1:0] exp_q,     exp_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  chk_clr;
   logic                  chk_add;
   logic [DATA_WIDTH-1:0] chk_sum;

   boot_chksum #(.DATA_WIDTH(DATA_WIDTH)) u_chksum (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (chk_clr),
      .add_en_i   (chk_add),
      .add_data_i (boot_mem_rd_data),
      .sum_o      (chk_sum)
   );

   // Next-state, counter and shadow-register update.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      words_d   = words_q;
      src_d     = src_q;
      dst_d     = dst_q;
      chk_en_d  = chk_en_q;
      exp_d     = exp_q;
      lat_cnt_d = lat_cnt_q;
      wr_data_d = wr_data_q;
      chk_clr   = 1'b0;
      chk_add   = 1'b0;
      case (state_q)
         ST_INIT: begin
            words_d  = (cfg_words == '0) ? ADDR_WIDTH'(DEFAULT_WORDS) : cfg_words;
            src_d    = cfg_src_base;
            dst_d    = cfg_dst_base;
            chk_en_d = cfg_chk_en;
            exp_d    = cfg_checksum;
            idx_d    = '0;
            chk_clr  = 1'b1;
            state_d  = ST_READ;
         end
         ST_READ: begin
            lat_cnt_d = LAT_W'(RD_LATENCY - 1);
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_cnt_q == '0) begin
               wr_data_d = boot_mem_rd_data;
               chk_add   = 1'b1;
               state_d   = ST_WRITE;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         ST_WRITE: begin
            if (inst_mem_ready) begin
               if (idx_q == words_q - ADDR_WIDTH'(1)) begin
                  state_d = ST_CHECK;
               end else begin
                  idx_d   = idx_q + ADDR_WIDTH'(1);
                  state_d = ST_READ;
               end
            end
         end
         ST_CHECK: begin
            state_d = (chk_en_q && (chk_sum != exp_q)) ? ST_ERROR : ST_DONE;
         end
         ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d = ST_INIT;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State and datapath registers; reset aborts any copy in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         idx_q     <= '0;
         words_q   <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         chk_en_q  <= 1'b0;
         exp_q     <= '0;
         lat_cnt_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         words_q   <= words_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         chk_en_q  <= chk_en_d;
         exp_q     <= exp_d;
         lat_cnt_q <= lat_cnt_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Outputs depend only on registers, never on inputs.
   assign boot_mem_rd_en   = (state_q == ST_READ);
   assign boot_mem_addr    = src_q + idx_q;
   assign inst_mem_wr_en   = (state_q == ST_WRITE);
   assign inst_mem_addr    = dst_q + (idx_q << ADDR_SHIFT);
   assign inst_mem_wr_data = wr_data_q;
   assign boot_mode        = (state_q != ST_DONE);
   assign boot_done        = (state_q == ST_DONE);
   assign boot_err         = (state_q == ST_ERROR);
   assign checksum         = chk_sum;

endmodule

// File: tb/tb_bootloader_ctrl.sv
// Scoreboard bench for bootloader_ctrl with a latency-modelled boot ROM.
module tb_bootloader_ctrl;

   localparam int DW  = 32;
   localparam int AW  = 20;
   localparam int LAT = 3;
   localparam int SH  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] cfg_words = '0;
   logic [AW-1:0] cfg_src_base = '0;
   logic [AW-1:0] cfg_dst_base = '0;
   logic          cfg_chk_en = 1'b0;
   logic [DW-1:0] cfg_checksum = '0;
   logic          boot_mem_rd_en;
   logic [AW-1:0] boot_mem_addr;
   logic [DW-1:0] boot_mem_rd_data;
   logic          inst_mem_wr_en;
   logic          inst_mem_ready = 1'b1;
   logic [AW-1:0] inst_mem_addr;
   logic [DW-1:0] inst_mem_wr_data;
   logic          boot_mode;
   logic          boot_done;
   logic          boot_err;
   logic [DW-1:0] checksum;

   bootloader_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .ADDR_SHIFT(SH), .DEFAULT_WORDS('h120)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_words(cfg_words), .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
      .cfg_chk_en(cfg_chk_en), .cfg_checksum(cfg_checksum),
      .boot_mem_rd_en(boot_mem_rd_en), .boot_mem_addr(boot_mem_addr),
      .boot_mem_rd_data(boot_mem_rd_data),
      .inst_mem_wr_en(inst_mem_wr_en), .inst_mem_ready(inst_mem_ready),
      .inst_mem_addr(inst_mem_addr), .inst_mem_wr_data(inst_mem_wr_data),
      .boot_mode(boot_mode), .boot_done(boot_done), .boot_err(boot_err),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      case (a)
         20'h800: rom_word = 32'h0000_0001;
         20'h801: rom_word = 32'h0000_0002;
         20'h802: rom_word = 32'h0000_0003;
         20'h803: rom_word = 32'hFFFF_FFFF;
         default: rom_word = {a[11:0], a};
      endcase
   endfunction

   // Boot ROM: data appears exactly LAT cycles after the strobe, garbage otherwise.
   logic [AW-1:0] pipe_addr [LAT] = '{default: '0};
   logic          pipe_vld  [LAT] = '{default: 1'b0};
   always @(posedge clk) begin
      pipe_addr[0] <= boot_mem_addr;
      pipe_vld[0]  <= boot_mem_rd_en;
      for (int i = 1; i < LAT; i++) begin
         pipe_addr[i] <= pipe_addr[i-1];
         pipe_vld[i]  <= pipe_vld[i-1];
      end
   end
   assign boot_mem_rd_data = pipe_vld[LAT-1] ? rom_word(pipe_addr[LAT-1]) : 32'hDEAD_BEEF;

   // Back-pressure: hold ready low for bp_left cycles when bp_addr is written.
   logic [AW-1:0] bp_addr = '1;
   int            bp_left = 0;
   always @(posedge clk) begin
      #1;
      if (bp_left > 0 && inst_mem_wr_en && inst_mem_addr == bp_addr) begin
         inst_mem_ready = 1'b0;
         bp_left--;
      end else begin
         inst_mem_ready = 1'b1;
      end
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   typedef struct packed {
      logic          done;
      logic          err;
      logic          mode;
      logic [DW-1:0] sum;
   } st_t;

   wr_t wr_q[$];
   st_t st_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write-request cycle must show the head of the expected queue.
   logic [AW-1:0] watch_addr = '1;
   int            hold_cnt = 0;
   logic          prev_end = 1'b0;
   always @(negedge clk) begin
      if (inst_mem_wr_en && !rst) begin
         if (inst_mem_addr == watch_addr) hold_cnt++;
         if (wr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", inst_mem_addr, inst_mem_wr_data);
         end else begin
            check("wr_addr", inst_mem_addr, wr_q[0].addr);
            check("wr_data", inst_mem_wr_data, wr_q[0].data);
            if (inst_mem_ready) void'(wr_q.pop_front());
         end
      end
      if ((boot_done || boot_err) && !prev_end) begin
         if (st_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL status_unexpected: got done=%0b err=%0b, expected no completion", boot_done, boot_err);
         end else begin
            st_t s;
            s = st_q.pop_front();
            check("st_done", boot_done, s.done);
            check("st_err", boot_err, s.err);
            check("st_mode", boot_mode, s.mode);
            check("st_sum", checksum, s.sum);
         end
      end
      prev_end = boot_done || boot_err;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_writes(input int n, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                              output logic [DW-1:0] sum);
      sum = '0;
      for (int i = 0; i < n; i++) begin
         wr_t w;
         w.addr = dst + AW'(i << SH);
         w.data = rom_word(src + AW'(i));
         wr_q.push_back(w);
         sum = sum + w.data;
      end
   endtask

   task automatic expect_copy(input int n, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                              input logic exp_err);
      logic [DW-1:0] sum;
      st_t s;
      push_writes(n, src, dst, sum);
      s.done = !exp_err;
      s.err  = exp_err;
      s.mode = exp_err;
      s.sum  = sum;
      st_q.push_back(s);
   endtask

   task automatic pulse_start(output int t0);
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_end(input int t0, input int exp_cyc, input string name);
      int n = 0;
      while (!(boot_done || boot_err) && n < 3000) begin
         step();
         n++;
      end
      if (!(boot_done || boot_err)) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got timeout after %0d cycles, expected completion at %0d", name, n, exp_cyc);
      end else begin
         check(name, cyc - t0, exp_cyc);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rd_en"}, boot_mem_rd_en, 0);
      check({tag, "_wr_en"}, inst_mem_wr_en, 0);
      check({tag, "_rd_addr"}, boot_mem_addr, 0);
      check({tag, "_wr_addr"}, inst_mem_addr, 0);
      check({tag, "_wr_data"}, inst_mem_wr_data, 0);
      check({tag, "_mode"}, boot_mode, 1);
      check({tag, "_done"}, boot_done, 0);
      check({tag, "_err"}, boot_err, 0);
      check({tag, "_sum"}, checksum, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
      $fatal(1);
   end

   initial begin
      int t0;
      int t_dummy;
      logic [DW-1:0] sum_dummy;

      repeat (3) step();
      check_reset_values("reset");

      // Default image: cfg_words = 0 selects 'h120 words.
      expect_copy('h120, 20'h0, 20'h0, 1'b0);
      rst = 1'b0;
      t0 = cyc;
      wait_end(t0, 2 + 'h120 * (LAT + 2), "t1_cycles");

      // Offsets; a mid-copy start and cfg changes must be ignored.
      cfg_words = 20'd4; cfg_src_base = 20'h10; cfg_dst_base = 20'h100;
      expect_copy(4, 20'h10, 20'h100, 1'b0);
      pulse_start(t0);
      repeat (4) step();
      cfg_words = 20'd9; cfg_src_base = 20'h55; cfg_dst_base = 20'h300;
      pulse_start(t_dummy);
      wait_end(t0, 3 + 4 * (LAT + 2), "t2_cycles");
      repeat (4) step();
      check("t2_start_not_queued", boot_done, 1);

      // Back-pressure on word 2 for three cycles.
      cfg_words = 20'd4; cfg_src_base = 20'h10; cfg_dst_base = 20'h100;
      expect_copy(4, 20'h10, 20'h100, 1'b0);
      bp_addr = 20'h108; bp_left = 3; watch_addr = 20'h108; hold_cnt = 0;
      pulse_start(t0);
      wait_end(t0, 3 + 4 * (LAT + 2) + 3, "t3_cycles");
      check("t3_hold_cycles", hold_cnt, 4);
      watch_addr = '1;

      // Checksum 1+2+3+FFFFFFFF = 5: pass, then fail with 6, then rerun from ERROR.
      cfg_words = 20'd4; cfg_src_base = 20'h800; cfg_dst_base = 20'h0;
      cfg_chk_en = 1'b1; cfg_checksum = 32'd5;
      expect_copy(4, 20'h800, 20'h0, 1'b0);
      pulse_start(t0);
      wait_end(t0, 3 + 4 * (LAT + 2), "t4_pass_cycles");
      check("t4_sum", checksum, 32'd5);
      cfg_checksum = 32'd6;
      expect_copy(4, 20'h800, 20'h0, 1'b1);
      pulse_start(t0);
      wait_end(t0, 3 + 4 * (LAT + 2), "t4_fail_cycles");
      repeat (3) step();
      check("t4_err_hold", boot_err, 1);
      check("t4_mode_hold", boot_mode, 1);
      cfg_checksum = 32'd5;
      expect_copy(4, 20'h800, 20'h0, 1'b0);
      pulse_start(t0);
      wait_end(t0, 3 + 4 * (LAT + 2), "t4_rerun_cycles");

      // Single-word image.
      cfg_chk_en = 1'b0;
      cfg_words = 20'd1; cfg_src_base = 20'h30; cfg_dst_base = 20'h40;
      expect_copy(1, 20'h30, 20'h40, 1'b0);
      pulse_start(t0);
      wait_end(t0, 3 + (LAT + 2), "t5_cycles");

      // Source and destination wrap-around.
      cfg_words = 20'd4; cfg_src_base = 20'hFFFFE; cfg_dst_base = 20'hFFFF8;
      expect_copy(4, 20'hFFFFE, 20'hFFFF8, 1'b0);
      pulse_start(t0);
      wait_end(t0, 3 + 4 * (LAT + 2), "t6_cycles");

      // Reset during the stalled write of word 7, then automatic restart.
      cfg_words = 20'd10; cfg_src_base = 20'h0; cfg_dst_base = 20'h200;
      push_writes(8, 20'h0, 20'h200, sum_dummy);
      bp_addr = 20'h21C; bp_left = 3;
      pulse_start(t0);
      begin
         int n = 0;
         while (!(inst_mem_wr_en && inst_mem_addr == 20'h21C) && n < 200) begin
            step();
            n++;
         end
         if (!(inst_mem_wr_en && inst_mem_addr == 20'h21C)) begin
            n_checks++;
            n_errors++;
            $display("FAIL t7_reach_word7: got timeout, expected write of word 7");
         end
      end
      rst = 1'b1;
      step();
      bp_left = 0;
      check_reset_values("t7_abort");
      check("t7_word7_unaccepted", wr_q.size(), 1);
      wr_q.delete();
      step();
      expect_copy(10, 20'h0, 20'h200, 1'b0);
      rst = 1'b0;
      t0 = cyc;
      wait_end(t0, 2 + 10 * (LAT + 2), "t7_restart_cycles");

      repeat (3) step();
      check("end_wr_queue", wr_q.size(), 0);
      check("end_st_queue", st_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
